// File: rtl/axi4_sf_fifo_pkg.sv
// Shared types for the AXI4 write store-and-forward FIFO.
// W-channel state and length-checker mode strings.
`timescale 1ns/1ps
package axi4_sf_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wstate_e;

  localparam string LEN_CHECK_ON  = "ON";
  localparam string LEN_CHECK_OFF = "OFF";

endpackage

// File: rtl/axi_inf.sv
// AXI4 write-channel bundle (AW/W/B) with slave and master views.
// Widths are carried by the interface parameters.
`timescale 1ns/1ps
interface axi_inf #(
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int IDSIZE = 4,
  parameter int DSIZE  = 32
);
  logic [IDSIZE-1:0] awid;
  logic [ASIZE-1:0]  awaddr;
  logic [LSIZE-1:0]  awlen;
  logic              awvalid;
  logic              awready;
  logic [DSIZE-1:0]  wdata;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [IDSIZE-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slaver_wr (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master_wr (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Push into a full FIFO is dropped; pop of an empty one is ignored.
`timescale 1ns/1ps
module sync_fwft_fifo #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] din,
  input  logic             pop,
  output logic [DSIZE-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axi4_wr_store_forward_fifo.sv
// AXI4 write store-and-forward FIFO: a burst is released on the
// output only after all of its W beats have been stored.
`timescale 1ns/1ps
module axi4_wr_store_forward_fifo
  import axi4_sf_fifo_pkg::*;
#(
  parameter int    DEPTH      = 4,
  parameter int    DATA_DEPTH = 512,
  parameter string LEN_CHECK  = "ON"
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  axi_inf.slaver_wr              axi_in,
  axi_inf.master_wr              axi_out,
  output logic [$clog2(DEPTH):0] pkt_cnt,
  output logic                   len_err
);
  localparam int  IDSIZE = $bits(axi_in.awid);
  localparam int  ASIZE  = $bits(axi_in.awaddr);
  localparam int  LSIZE  = $bits(axi_in.awlen);
  localparam int  DSIZE  = $bits(axi_in.wdata);
  localparam int  AWW    = IDSIZE + ASIZE + LSIZE;
  localparam int  CW     = $clog2(DEPTH) + 1;
  localparam bit  LEN_ON = (LEN_CHECK == LEN_CHECK_ON);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic             ready_en;
  logic             commit_q;
  logic [CW-1:0]    committed;
  logic [CW-1:0]    outstanding;
  wstate_e          state;
  logic [LSIZE-1:0] beat_cnt;

  logic [AWW-1:0]      aw_dout;
  logic [DSIZE:0]      w_dout;
  logic [IDSIZE+1:0]   b_dout;
  logic aw_empty, aw_full;
  logic w_empty, w_full;
  logic b_empty, b_full;
  logic aw_rdy, w_rdy;
  logic aw_push, w_push;
  logic aw_vld, w_vld;
  logic aw_go, w_go;
  logic b_in_go, b_out_go;
  logic w_last;

  // Handshakes stay off until the first clock after reset release.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) ready_en <= 1'b0;
    else              ready_en <= 1'b1;
  end

  assign aw_rdy   = ready_en && !aw_full;
  assign w_rdy    = ready_en && !w_full;
  assign aw_push  = axi_in.awvalid && aw_rdy;
  assign w_push   = axi_in.wvalid && w_rdy;
  assign w_last   = w_dout[0];
  assign aw_vld   = (state == IDLE) && !aw_empty &&
                    (committed != '0) && (outstanding < DEPTH_C);
  assign w_vld    = (state == BURST) && !w_empty;
  assign aw_go    = aw_vld && axi_out.awready;
  assign w_go     = w_vld && axi_out.wready;
  assign b_in_go  = !b_empty && axi_in.bready;
  assign b_out_go = axi_out.bvalid && ready_en;

  assign axi_in.awready  = aw_rdy;
  assign axi_in.wready   = w_rdy;
  assign axi_in.bvalid   = !b_empty;
  assign {axi_in.bid, axi_in.bresp} = b_dout;

  assign axi_out.awvalid = aw_vld;
  assign {axi_out.awid, axi_out.awaddr, axi_out.awlen} = aw_dout;
  assign axi_out.wvalid  = w_vld;
  assign axi_out.wdata   = w_dout[DSIZE:1];
  assign axi_out.wlast   = w_last;
  assign axi_out.bready  = ready_en;

  assign pkt_cnt = committed;

  sync_fwft_fifo #(.DSIZE(AWW), .DEPTH(DEPTH)) u_aw_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (aw_push),
    .din   ({axi_in.awid, axi_in.awaddr, axi_in.awlen}),
    .pop   (aw_go),
    .dout  (aw_dout),
    .empty (aw_empty),
    .full  (aw_full)
  );

  sync_fwft_fifo #(.DSIZE(DSIZE+1), .DEPTH(DATA_DEPTH)) u_w_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (w_push),
    .din   ({axi_in.wdata, axi_in.wlast}),
    .pop   (w_go),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  sync_fwft_fifo #(.DSIZE(IDSIZE+2), .DEPTH(DEPTH)) u_b_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (b_out_go),
    .din   ({axi_out.bid, axi_out.bresp}),
    .pop   (b_in_go),
    .dout  (b_dout),
    .empty (b_empty),
    .full  (b_full)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      commit_q    <= 1'b0;
      committed   <= '0;
      outstanding <= '0;
    end else begin
      commit_q <= w_push && axi_in.wlast;
      case ({commit_q, aw_go})
        2'b10:   committed <= committed + CW'(1);
        2'b01:   committed <= committed - CW'(1);
        default: committed <= committed;
      endcase
      case ({aw_go, b_in_go})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Length mismatch is flagged but the data still goes out as stored.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (aw_go) begin
            state    <= BURST;
            beat_cnt <= aw_dout[LSIZE-1:0];
          end
        end
        BURST: begin
          if (w_go) begin
            if (w_last) state <= IDLE;
            else if (beat_cnt != '0) beat_cnt <= beat_cnt - LSIZE'(1);
            if (LEN_ON && (w_last != (beat_cnt == '0))) len_err <= 1'b1;
          end
        end
      endcase
    end
  end

  a_commit_under: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    !(aw_go && !commit_q && committed == '0));
  a_commit_over: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    !(commit_q && !aw_go && committed == '1));
  a_ostd_under: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    !(b_in_go && !aw_go && outstanding == '0));
  a_ostd_over: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    !(aw_go && !b_in_go && outstanding == DEPTH_C));
  a_b_over: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
    !(b_out_go && b_full));

endmodule

// File: tb/tb_axi4_wr_store_forward_fifo.sv
// Scoreboard bench for the AXI4 write store-and-forward FIFO.
// Directed bursts with hand-computed expectations.
`timescale 1ns/1ps
module tb_axi4_wr_store_forward_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi_inf #(.ASIZE(32), .LSIZE(8), .IDSIZE(4), .DSIZE(32)) in_if ();
  axi_inf #(.ASIZE(32), .LSIZE(8), .IDSIZE(4), .DSIZE(32)) out_if ();

  logic [2:0] pkt_cnt;
  logic       len_err;

  axi4_wr_store_forward_fifo #(
    .DEPTH      (4),
    .DATA_DEPTH (256),
    .LEN_CHECK  ("ON")
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .axi_in      (in_if),
    .axi_out     (out_if),
    .pkt_cnt     (pkt_cnt),
    .len_err     (len_err)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  b_t  exp_b[$];
  int  aw_hs_cyc[$];
  int  b_hs_cyc[$];
  int  errs = 0;
  int  checks = 0;
  int  wlast_cyc = 0;
  int  aw_rise_cyc = 0;
  int  w_sent = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] resp_of(input logic [3:0] id);
    return id[1:0] ^ 2'b10;
  endfunction

  // Scoreboard monitor: sampled on the falling edge.
  initial begin
    aw_t e_aw;
    w_t  e_w;
    b_t  e_b;
    logic prev_awv;
    prev_awv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_awv = 1'b0;
      end else begin
        if (out_if.awvalid && !prev_awv) aw_rise_cyc = cyc;
        prev_awv = out_if.awvalid;
        if (out_if.awvalid && out_if.awready) begin
          aw_hs_cyc.push_back(cyc);
          if (exp_aw.size() == 0) begin
            checks++; errs++;
            $display("FAIL aw_unexpected: got id %0h", out_if.awid);
          end else begin
            e_aw = exp_aw.pop_front();
            chk("aw", {out_if.awid, out_if.awaddr, out_if.awlen}, e_aw);
          end
        end
        if (out_if.wvalid && out_if.wready) begin
          if (exp_w.size() == 0) begin
            checks++; errs++;
            $display("FAIL w_unexpected: got %0h", out_if.wdata);
          end else begin
            e_w = exp_w.pop_front();
            chk("w", {out_if.wdata, out_if.wlast}, e_w);
          end
        end
        if (in_if.bvalid && in_if.bready) begin
          b_hs_cyc.push_back(cyc);
          if (exp_b.size() == 0) begin
            checks++; errs++;
            $display("FAIL b_unexpected: got id %0h", in_if.bid);
          end else begin
            e_b = exp_b.pop_front();
            chk("b", {in_if.bid, in_if.bresp}, e_b);
          end
        end
      end
    end
  end

  // Downstream slave: one B per completed burst, in AW order.
  initial begin
    logic [3:0] slv_id[$];
    b_t   pend_b[$];
    b_t   t;
    logic aw_h, w_l, b_h;
    logic [3:0] cap_id;
    out_if.bvalid = 1'b0;
    out_if.bid    = '0;
    out_if.bresp  = '0;
    forever begin
      @(negedge clk);
      aw_h   = rst_n && out_if.awvalid && out_if.awready;
      cap_id = out_if.awid;
      w_l    = rst_n && out_if.wvalid && out_if.wready && out_if.wlast;
      b_h    = out_if.bvalid && out_if.bready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        slv_id.delete();
        pend_b.delete();
        out_if.bvalid = 1'b0;
      end else begin
        if (aw_h) slv_id.push_back(cap_id);
        if (w_l && slv_id.size() > 0) begin
          t.id   = slv_id.pop_front();
          t.resp = resp_of(t.id);
          pend_b.push_back(t);
        end
        if (b_h) out_if.bvalid = 1'b0;
        if (!out_if.bvalid && pend_b.size() > 0) begin
          t = pend_b.pop_front();
          out_if.bid    = t.id;
          out_if.bresp  = t.resp;
          out_if.bvalid = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    int n;
    in_if.awid    = id;
    in_if.awaddr  = addr;
    in_if.awlen   = len;
    in_if.awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_if.awready && n < 3000);
    if (!in_if.awready) begin
      checks++; errs++;
      $display("FAIL aw_timeout: awready %0d required 1", in_if.awready);
    end
    tick();
    in_if.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic last, input int gap);
    int n;
    in_if.wdata  = d;
    in_if.wlast  = last;
    in_if.wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_if.wready && n < 3000);
    if (!in_if.wready) begin
      checks++; errs++;
      $display("FAIL w_timeout: wready %0d required 1", in_if.wready);
    end
    if (last) wlast_cyc = cyc;
    tick();
    in_if.wvalid = 1'b0;
    w_sent++;
    repeat (gap) tick();
  endtask

  task automatic expect_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [31:0] base,
                              input int nbeats);
    aw_t a;
    w_t  w;
    b_t  b;
    a.id = id; a.addr = addr; a.len = len;
    exp_aw.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      w.data = base + 32'(i);
      w.last = (i == nbeats - 1);
      exp_w.push_back(w);
    end
    b.id = id; b.resp = resp_of(id);
    exp_b.push_back(b);
  endtask

  task automatic send_beats(input logic [31:0] base, input int nbeats,
                            input int gap);
    for (int i = 0; i < nbeats; i++)
      send_w(base + 32'(i), i == nbeats - 1, gap);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_aw.size() + exp_w.size() + exp_b.size()) != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_aw.size() + exp_w.size() + exp_b.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, in_if.awready, 1'b0);
    chk({tag, "_wready"},  in_if.wready, 1'b0);
    chk({tag, "_bvalid"},  in_if.bvalid, 1'b0);
    chk({tag, "_awvalid"}, out_if.awvalid, 1'b0);
    chk({tag, "_wvalid"},  out_if.wvalid, 1'b0);
    chk({tag, "_bready"},  out_if.bready, 1'b0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 3'd0);
    chk({tag, "_len_err"}, len_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_aw;
    int base_b;
    int base_w;
    int n;
    in_if.awvalid = 1'b0;
    in_if.awid    = '0;
    in_if.awaddr  = '0;
    in_if.awlen   = '0;
    in_if.wvalid  = 1'b0;
    in_if.wdata   = '0;
    in_if.wlast   = 1'b0;
    in_if.bready  = 1'b1;
    out_if.awready = 1'b1;
    out_if.wready  = 1'b1;

    repeat (3) tick();
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_awready", in_if.awready, 1'b0);
    chk("rel_bready", out_if.bready, 1'b0);
    tick();
    chk("run_awready", in_if.awready, 1'b1);
    chk("run_bready", out_if.bready, 1'b1);

    // Single burst, latency and pkt_cnt sequence
    expect_burst(4'h1, 32'h100, 8'd3, 32'h1000_0000, 4);
    send_aw(4'h1, 32'h100, 8'd3);
    send_beats(32'h1000_0000, 4, 0);
    @(negedge clk);
    chk("t1_pkt_a", pkt_cnt, 3'd0);
    chk("t1_awv_a", out_if.awvalid, 1'b0);
    @(negedge clk);
    chk("t1_pkt_b", pkt_cnt, 3'd1);
    chk("t1_awv_b", out_if.awvalid, 1'b1);
    @(negedge clk);
    chk("t1_pkt_c", pkt_cnt, 3'd0);
    chk("t1_lat", 64'(aw_rise_cyc - wlast_cyc), 64'd2);
    tick();
    wait_drain("t1_drain");

    // Store-and-forward with gaps between beats
    expect_burst(4'h2, 32'h200, 8'd7, 32'h2000_0000, 8);
    send_aw(4'h2, 32'h200, 8'd7);
    for (int i = 0; i < 7; i++) begin
      send_w(32'h2000_0000 + 32'(i), 1'b0, 0);
      repeat (2) begin
        @(negedge clk);
        chk("t2_hold", out_if.awvalid, 1'b0);
        tick();
      end
    end
    send_w(32'h2000_0007, 1'b1, 0);
    @(negedge clk);
    chk("t2_awv_a", out_if.awvalid, 1'b0);
    @(negedge clk);
    chk("t2_awv_b", out_if.awvalid, 1'b1);
    tick();
    chk("t2_lat", 64'(aw_rise_cyc - wlast_cyc), 64'd2);
    wait_drain("t2_drain");

    // Outstanding limit with upstream B held off
    in_if.bready = 1'b0;
    base_aw = aw_hs_cyc.size();
    base_b  = b_hs_cyc.size();
    for (int k = 0; k < 6; k++)
      expect_burst(4'(8 + k), 32'h300 + 32'(k * 16), 8'd0,
                   32'h3000_0000 + 32'(k), 1);
    fork
      for (int k = 0; k < 6; k++)
        send_aw(4'(8 + k), 32'h300 + 32'(k * 16), 8'd0);
      for (int k = 0; k < 6; k++)
        send_w(32'h3000_0000 + 32'(k), 1'b1, 0);
    join
    repeat (20) @(negedge clk);
    chk("t3_aw_cnt", 64'(aw_hs_cyc.size() - base_aw), 64'd4);
    chk("t3_bvalid", in_if.bvalid, 1'b1);
    tick();
    in_if.bready = 1'b1;
    wait_drain("t3_drain");
    if (aw_hs_cyc.size() > base_aw + 4 && b_hs_cyc.size() > base_b)
      chk("t3_aw5_lat", 64'(aw_hs_cyc[base_aw + 4] - b_hs_cyc[base_b]), 64'd1);
    else begin
      checks++; errs++;
      $display("FAIL t3_aw5: aw %0d b %0d handshakes", aw_hs_cyc.size() - base_aw,
               b_hs_cyc.size() - base_b);
    end

    // Short burst raises len_err; following burst is clean
    chk("t4_err_pre", len_err, 1'b0);
    expect_burst(4'h5, 32'h500, 8'd3, 32'h5000_0000, 2);
    send_aw(4'h5, 32'h500, 8'd3);
    send_beats(32'h5000_0000, 2, 0);
    wait_drain("t4_drain_a");
    chk("t4_err_set", len_err, 1'b1);
    expect_burst(4'h6, 32'h600, 8'd1, 32'h6000_0000, 2);
    send_aw(4'h6, 32'h600, 8'd1);
    send_beats(32'h6000_0000, 2, 0);
    wait_drain("t4_drain_b");
    chk("t4_err_sticky", len_err, 1'b1);

    // Full data FIFO, output stalled
    out_if.wready = 1'b0;
    base_w = w_sent;
    expect_burst(4'h7, 32'h700, 8'd255, 32'h7000_0000, 256);
    expect_burst(4'h9, 32'h900, 8'd255, 32'h9000_0000, 256);
    send_aw(4'h7, 32'h700, 8'd255);
    send_aw(4'h9, 32'h900, 8'd255);
    fork
      begin
        send_beats(32'h7000_0000, 256, 0);
        send_beats(32'h9000_0000, 256, 0);
      end
      begin
        n = 0;
        while (w_sent < base_w + 256 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        chk("t5_wready_low", in_if.wready, 1'b0);
        chk("t5_beats_in", 64'(w_sent - base_w), 64'd256);
        chk("t5_wvalid", out_if.wvalid, 1'b1);
        tick();
        out_if.wready = 1'b1;
      end
    join
    wait_drain("t5_drain");
    chk("t5_wready_back", in_if.wready, 1'b1);

    // Reset during beat 3 of an 8-beat burst
    send_aw(4'hA, 32'hA00, 8'd7);
    send_w(32'hA000_0000, 1'b0, 0);
    send_w(32'hA000_0001, 1'b0, 0);
    in_if.wdata  = 32'hA000_0002;
    in_if.wlast  = 1'b0;
    in_if.wvalid = 1'b1;
    chk("t6_pkt_pre", pkt_cnt, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    in_if.wvalid = 1'b0;
    check_reset_outputs("t6");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_wready", in_if.wready, 1'b0);
    tick();
    expect_burst(4'hB, 32'hB00, 8'd3, 32'hB000_0000, 4);
    send_aw(4'hB, 32'hB00, 8'd3);
    send_beats(32'hB000_0000, 4, 0);
    wait_drain("t6_drain");
    chk("t6_pkt_post", pkt_cnt, 3'd0);
    chk("t6_err_post", len_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/axi4_wr_store_forward_fifo.md
AXI4_WR_STORE_FORWARD_FIFO -- requirements
Module: axi4_wr_store_forward_fifo

Interface
REQ-001 Parameter DEPTH, 4: AW slots and maximum outstanding output bursts; power of 2, range 2..16.
REQ-002 Parameter DATA_DEPTH, 512: W words stored; power of 2, at least 256.
REQ-003 Parameter LEN_CHECK, "ON": "ON" enables the burst-length checker; "OFF" ties len_err to 0.
REQ-004 axi_aclk  in  1  single clock for both AXI sides; `timescale 1ns/1ps.
REQ-005 axi_aresetn  in  1  asynchronous, active-low reset.
REQ-006 axi_in  axi_inf.slaver_wr  AW/W/B slave port; ASIZE, LSIZE, IDSIZE and DSIZE are taken from the interface.
REQ-007 axi_out  axi_inf.master_wr  AW/W/B master port with the same widths as axi_in.
REQ-008 pkt_cnt  out  $clog2(DEPTH)+1  number of fully stored bursts not yet issued on axi_out AW.
REQ-009 len_err  out  1  sticky flag: a stored burst's beat count differed from awlen+1.

Function
REQ-010 axi_in AW SHALL be accepted into the AW FIFO ({awid,awaddr,awlen}) when the FIFO is not full; axi_in.awready = !aw_full.
REQ-011 axi_in W SHALL be accepted into the data FIFO ({wdata,wlast}) when the FIFO is not full; axi_in.wready = !data_full.
REQ-012 Each accepted axi_in beat with wlast=1 SHALL increment the committed counter, registered, one cycle later.
REQ-013 axi_out.awvalid SHALL be asserted only when all three hold: the AW FIFO is not empty, the committed counter is > 0, and outstanding < DEPTH.
REQ-014 Minimum latency from the input wlast handshake to axi_out.awvalid SHALL be 2 cycles.
REQ-015 An axi_out AW handshake SHALL pop the AW FIFO and decrement the committed counter.
- If a commit occurs in the same cycle, the counter holds its value.
REQ-016 The W state machine has two states: IDLE and BURST.
- IDLE -> BURST on an axi_out AW handshake; beat_cnt is loaded with awlen.
- BURST -> IDLE on an axi_out W handshake with the stored wlast=1.
REQ-017 axi_out.wvalid SHALL be 1 only in BURST while the data FIFO is not empty.
- wdata and wlast come from the FIFO head, first-word-fall-through.
- The first beat is valid no earlier than the cycle after the AW handshake.
REQ-018 A new axi_out AW SHALL NOT be issued while in BURST.
- AW SHALL be issued before W for every burst, and bursts SHALL NOT interleave.
REQ-019 Length check, when LEN_CHECK="ON", SHALL set len_err on either condition:
- the stored wlast=1 occurs while beat_cnt != 0;
- beat_cnt reaches 0 with the stored wlast=0.
- Data SHALL be forwarded unmodified in both cases.
REQ-020 The outstanding counter SHALL increment on an axi_out AW handshake and decrement on an axi_in B handshake.
- If both occur in the same cycle, the counter holds.
REQ-021 B path: axi_out.bready SHALL be constant 1.
- {bid,bresp} SHALL be written to a DEPTH-entry B FIFO that, by REQ-013, never overflows.
- axi_in.bvalid = !b_empty, driving the B FIFO head.
REQ-022 A push to and pop from the same FIFO in the same cycle SHALL both be performed, at any fill level.
- Exception: a push into a full FIFO is blocked by its ready.
REQ-023 A burst of up to 256 beats SHALL always complete.
- With DATA_DEPTH >= 256, draining committed bursts guarantees room; no deadlock.
REQ-024 All counters SHALL saturate-check in simulation: an assertion SHALL fire on underflow or overflow.

Reset
REQ-025 On axi_aresetn=0 the following SHALL clear asynchronously:
- all FIFO pointers, all counters and beat_cnt;
- the W state (forced to IDLE);
- len_err and pkt_cnt (both 0).
REQ-026 During reset and on the first clock after release the following SHALL be 0: axi_in.awready, axi_in.wready, axi_in.bvalid, axi_out.awvalid, axi_out.wvalid, axi_out.bready.
REQ-027 A reset asserted mid-burst SHALL discard all stored AW, W and B contents; no partial burst is replayed.

Structure
REQ-028 Package axi4_sf_fifo_pkg SHALL hold the W-state enum (IDLE, BURST) and the LEN_CHECK string constants.
REQ-029 One sub-module, sync_fwft_fifo (parameters DSIZE and DEPTH; outputs empty and full), SHALL be instantiated three times: AW, data and B.

Verification
REQ-030 Single burst: AW awlen=3, then 4 W beats back-to-back -> axi_out.awvalid 2 cycles after the input wlast; 4 W beats out in order, with wlast on beat 4; pkt_cnt goes 0->1->0.
REQ-031 Store-and-forward: AW awlen=7, W beats with gaps, axi_out.awready=1 -> axi_out.awvalid stays 0 until the 8th input beat is accepted.
REQ-032 Outstanding limit: with DEPTH=4, issue 6 bursts of awlen=0 while holding axi_in.bready=0 -> exactly 4 AW handshakes on axi_out; the 5th follows 1 cycle after the first axi_in B handshake.
REQ-033 Length error: AW awlen=3 with wlast on beat 2 -> len_err=1 and stays 1; 2 beats are forwarded; the next correct burst passes unaltered.
REQ-034 Full data FIFO: with DATA_DEPTH=256, write 2 bursts of awlen=255 with axi_out.wready=0 -> axi_in.wready drops after 256 beats and resumes once output drains; all 512 beats arrive intact.
REQ-035 Reset mid-operation: assert axi_aresetn=0 during beat 3 of 8 -> all valids 0 and pkt_cnt=0; the next burst after release completes normally.
